// File: rtl/lift_req_latch.sv
// Request front-end for the three-floor lift: button synchronisation and
// edge detection, pending-request latch, travel pacing for the floor FSM
// and door dwell sequencing.
module lift_req_latch #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_call,
    input  logic [2:0] cur_floor,
    output logic [2:0] req_floor,
    output logic       start,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SETTLE,
        DOOR
    } state_t;

    localparam logic [7:0] TRAV_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    logic [2:0] btn_s1;
    logic [2:0] btn_s2;
    logic [2:0] btn_prev;
    logic [2:0] btn_rise;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] trav_cnt;
    logic [7:0] trav_nxt;
    logic [7:0] door_cnt;
    logic [7:0] door_nxt;
    logic [2:0] pending_nxt;
    logic [2:0] set_mask;
    logic       enter_door;
    logic       go_decide;
    logic       start_nxt;

    logic       floor_valid;
    logic [2:0] floor_mask;
    logic       match;
    logic       reopen;

    // Two-flop synchroniser per button, then a registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            btn_rise <= '0;
        end else begin
            btn_s1   <= btn_call;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            btn_rise <= btn_s2 & ~btn_prev;
        end
    end

    // Floor decode: a malformed cur_floor matches nothing and clears nothing.
    always_comb begin
        floor_valid = (cur_floor == 3'b001) || (cur_floor == 3'b010) ||
                      (cur_floor == 3'b100);
        floor_mask  = floor_valid ? cur_floor : '0;
        match       = |(pending & floor_mask);
        reopen      = |(btn_rise & floor_mask);
        req_floor   = pending & ~cur_floor;
    end

    // Next-state, counter and request-register logic.
    always_comb begin
        state_nxt  = state;
        trav_nxt   = trav_cnt;
        door_nxt   = door_cnt;
        set_mask   = btn_rise;
        enter_door = 1'b0;
        go_decide  = 1'b0;

        case (state)
            IDLE, SETTLE: go_decide = 1'b1;
            MOVE: begin
                if (trav_cnt == '0) begin
                    state_nxt = SETTLE;
                end else begin
                    trav_nxt = trav_cnt - 8'd1;
                end
            end
            DOOR: begin
                // A press at the floor being served re-opens instead of latching.
                set_mask = btn_rise & ~floor_mask;
                if (reopen) begin
                    door_nxt = DOOR_LOAD;
                end else if (door_cnt == '0) begin
                    go_decide = 1'b1;
                end else begin
                    door_nxt = door_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (go_decide) begin
            if (match) begin
                state_nxt  = DOOR;
                door_nxt   = DOOR_LOAD;
                enter_door = 1'b1;
            end else if (|req_floor) begin
                state_nxt = MOVE;
                trav_nxt  = TRAV_LOAD;
            end else begin
                state_nxt = IDLE;
            end
        end

        // The clear on door entry overrides a same-cycle press of that floor.
        pending_nxt = (pending | set_mask) & ~(enter_door ? floor_mask : 3'b000);

        // start is registered, so it is raised for the MOVE cycle whose count is 0.
        start_nxt = (state_nxt == MOVE) && (trav_nxt == '0);
    end

    // State, counters, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trav_cnt  <= '0;
            door_cnt  <= '0;
            pending   <= '0;
            start     <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            trav_cnt  <= trav_nxt;
            door_cnt  <= door_nxt;
            pending   <= pending_nxt;
            start     <= start_nxt;
            door_open <= (state_nxt == DOOR);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_lift_req_latch.sv
// Scoreboard bench for lift_req_latch with a small floor-FSM model.
module tb_lift_req_latch;

    localparam int EV_PEND   = 0;
    localparam int EV_BUSY   = 1;
    localparam int EV_START  = 2;
    localparam int EV_DOPEN  = 3;
    localparam int EV_DCLOSE = 4;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_call;
    logic [2:0] cur_floor = 3'b001;
    logic [2:0] floor_cmd;
    logic [2:0] req_floor;
    logic       start;
    logic       door_open;
    logic [2:0] pending;
    logic       busy;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    ev_t q[$];

    logic [2:0] m_pend  = 3'b000;
    logic       m_busy  = 1'b0;
    logic       m_start = 1'b0;
    logic       m_door  = 1'b0;

    always #5 clk = ~clk;

    lift_req_latch #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_call (btn_call),
        .cur_floor(cur_floor),
        .req_floor(req_floor),
        .start    (start),
        .door_open(door_open),
        .pending  (pending),
        .busy     (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Floor FSM model: steps one floor per start, upward while anything is above.
    always @(posedge clk) begin
        if (floor_cmd != 3'b000) begin
            cur_floor <= floor_cmd;
        end else if (start) begin
            case (cur_floor)
                3'b001:  cur_floor <= 3'b010;
                3'b010:  cur_floor <= req_floor[2] ? 3'b100 : 3'b001;
                3'b100:  cur_floor <= 3'b010;
                default: cur_floor <= cur_floor;
            endcase
        end
    end

    function automatic string kname(input int k);
        case (k)
            EV_PEND:  return "pending";
            EV_BUSY:  return "busy";
            EV_START: return "start";
            EV_DOPEN: return "door_rise";
            default:  return "door_fall";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ex(input int kind, input int c, input logic [2:0] v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [2:0] v);
        ev_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s val %b at cycle %0d, expected none",
                     kname(kind), v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val !== v) begin
                n_err++;
                $display("FAIL event: got %s val %b at cycle %0d, expected %s val %b at cycle %0d",
                         kname(kind), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: turns output changes into events and checks them against the queue.
    always @(negedge clk) begin
        if (pending !== m_pend) observe(EV_PEND, pending);
        if (busy !== m_busy) observe(EV_BUSY, {2'b00, busy});
        if (start === 1'b1) begin
            observe(EV_START, cur_floor);
            chk("start_back_to_back", {31'd0, m_start}, 32'd0);
        end
        if (door_open === 1'b1 && m_door === 1'b0) observe(EV_DOPEN, cur_floor);
        if (door_open === 1'b0 && m_door === 1'b1) observe(EV_DCLOSE, cur_floor);
        m_pend  = pending;
        m_busy  = busy;
        m_start = start;
        m_door  = door_open;
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        btn_call[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn_call[b] = 1'b0;
    endtask

    task automatic set_floor(input logic [2:0] f);
        floor_cmd = f;
        @(negedge clk);
        floor_cmd = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        rst_n     = 1'b1;
        btn_call  = 3'b000;
        floor_cmd = 3'b000;
        #1 rst_n = 1'b0;

        // Reset and idle: nothing latched, no motion, door shut.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {28'd0, pending, start}, 32'd0);
            chk("reset_door_busy", {30'd0, door_open, busy}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {26'd0, pending, start, door_open, busy}, 32'd0);
        end

        // Two-floor trip 001 -> 100 with a door dwell at the top.
        n0 = cyc;
        ex(EV_PEND,   n0 + 4,  3'b100);
        ex(EV_BUSY,   n0 + 5,  3'b001);
        ex(EV_START,  n0 + 8,  3'b001);
        ex(EV_START,  n0 + 13, 3'b010);
        ex(EV_PEND,   n0 + 15, 3'b000);
        ex(EV_DOPEN,  n0 + 15, 3'b100);
        ex(EV_BUSY,   n0 + 21, 3'b000);
        ex(EV_DCLOSE, n0 + 21, 3'b100);
        press(2, 3);
        wait_to(n0 + 5);
        chk("req_floor_trip", {29'd0, req_floor}, 32'd4);
        wait_to(n0 + 25);

        // Call at the current floor: door opens from IDLE, no step.
        set_floor(3'b010);
        n0 = cyc;
        ex(EV_PEND,   n0 + 4,  3'b010);
        ex(EV_PEND,   n0 + 5,  3'b000);
        ex(EV_BUSY,   n0 + 5,  3'b001);
        ex(EV_DOPEN,  n0 + 5,  3'b010);
        ex(EV_BUSY,   n0 + 11, 3'b000);
        ex(EV_DCLOSE, n0 + 11, 3'b010);
        press(1, 2);
        wait_to(n0 + 4);
        chk("req_floor_excl_cur", {29'd0, req_floor}, 32'd0);
        wait_to(n0 + 14);

        // Re-press during dwell clock 4: door stays open 10 clocks total.
        n0 = cyc;
        ex(EV_PEND,   n0 + 4,  3'b010);
        ex(EV_PEND,   n0 + 5,  3'b000);
        ex(EV_BUSY,   n0 + 5,  3'b001);
        ex(EV_DOPEN,  n0 + 5,  3'b010);
        ex(EV_BUSY,   n0 + 15, 3'b000);
        ex(EV_DCLOSE, n0 + 15, 3'b010);
        press(1, 2);
        wait_to(n0 + 5);
        press(1, 2);
        wait_to(n0 + 18);

        // Intermediate stop: floor two requested, floor one added mid-travel.
        set_floor(3'b001);
        n0 = cyc;
        ex(EV_PEND,   n0 + 4,  3'b100);
        ex(EV_BUSY,   n0 + 5,  3'b001);
        ex(EV_START,  n0 + 8,  3'b001);
        ex(EV_PEND,   n0 + 9,  3'b110);
        ex(EV_PEND,   n0 + 10, 3'b100);
        ex(EV_DOPEN,  n0 + 10, 3'b010);
        ex(EV_DCLOSE, n0 + 16, 3'b010);
        ex(EV_START,  n0 + 19, 3'b010);
        ex(EV_PEND,   n0 + 21, 3'b000);
        ex(EV_DOPEN,  n0 + 21, 3'b100);
        ex(EV_BUSY,   n0 + 27, 3'b000);
        ex(EV_DCLOSE, n0 + 27, 3'b100);
        press(2, 2);
        wait_to(n0 + 5);
        press(1, 2);
        wait_to(n0 + 9);
        chk("req_floor_midstop", {29'd0, req_floor}, 32'd4);
        wait_to(n0 + 30);

        // Malformed cur_floor: request latches but neither matches nor moves.
        set_floor(3'b011);
        n0 = cyc;
        ex(EV_PEND,   n0 + 4,  3'b001);
        ex(EV_PEND,   n0 + 10, 3'b000);
        ex(EV_BUSY,   n0 + 10, 3'b001);
        ex(EV_DOPEN,  n0 + 10, 3'b001);
        ex(EV_BUSY,   n0 + 16, 3'b000);
        ex(EV_DCLOSE, n0 + 16, 3'b001);
        press(0, 2);
        wait_to(n0 + 8);
        chk("bad_floor_req", {29'd0, req_floor}, 32'd0);
        chk("bad_floor_busy", {31'd0, busy}, 32'd0);
        set_floor(3'b001);
        wait_to(n0 + 20);

        // Reset during MOVE with trav_cnt=2 aborts the step.
        n0 = cyc;
        ex(EV_PEND, n0 + 4, 3'b100);
        ex(EV_BUSY, n0 + 5, 3'b001);
        ex(EV_PEND, n0 + 6, 3'b000);
        ex(EV_BUSY, n0 + 6, 3'b000);
        press(2, 2);
        wait_to(n0 + 5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort_outputs", {26'd0, pending, start, door_open, busy}, 32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_abort", {26'd0, pending, start, door_open, busy}, 32'd0);

        chk("events_outstanding", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lift_req_latch.md
Name: lift_req_latch

Overview:
- Request front-end of the three-floor lift controller. Sits directly upstream of the floor-state FSM.
- Synchronises and edge-detects the raw floor buttons, then latches them as pending requests.
- Drives the FSM's request vector and its one-cycle step enable, so the FSM advances exactly one floor per travel interval.
- Sequences the door dwell at each served floor and clears that floor's request when service starts.

Parameters:
TRAVEL_CYCLES, 8, clocks spent travelling between adjacent floors before each step pulse (legal range 2..255)
DOOR_CYCLES, 16, clocks door_open stays high per service (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_call  input  3  raw floor buttons, bit0=ground, bit1=floor one, bit2=floor two; asynchronous, level
cur_floor  input  3  one-hot current floor from the floor FSM (001/010/100)
req_floor  output  3  pending requests excluding the current floor, to the floor FSM
start  output  1  one-cycle step enable to the floor FSM
door_open  output  1  door command, high during dwell
pending  output  3  raw latched request register (status)
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - pending, start, door_open and busy are 0.
  - The synchroniser flops and the edge-history register are 0.
  - All counters are 0 and the state is IDLE.
  - Reset asserted mid-travel or mid-dwell aborts immediately. Requests are lost. No start pulse is emitted.
- Input path:
  - btn_call passes through two flops per bit, then a rising-edge detector (sync output AND NOT the registered previous value).
  - A press held before rising edge k sets its pending bit at edge k+3.
  - A held button produces one request only. A new request needs a release and a re-press.
- Request register:
  - A detected edge sets its pending bit.
  - A bit is cleared only on entry to DOOR, and only the bit matching cur_floor.
  - If a press and a clear hit the same bit in the same cycle, the clear wins. The press is absorbed because that floor is being served.
- req_floor = pending AND NOT cur_floor, combinational, at all times.
- match = |(pending & cur_floor). Any bit of cur_floor outside 001/010/100 yields no match and no cleared bit.
- Counters are 8-bit: trav_cnt and door_cnt.
- FSM states: IDLE, MOVE, SETTLE, DOOR.
- IDLE:
  - If match: go to DOOR. Load door_cnt=DOOR_CYCLES-1 and clear the matching pending bit.
  - Else if req_floor is nonzero: go to MOVE and load trav_cnt=TRAVEL_CYCLES-1.
  - Else stay in IDLE.
- MOVE:
  - trav_cnt decrements each cycle.
  - When trav_cnt==0, start=1 for exactly that cycle, then go to SETTLE.
  - The floor FSM updates cur_floor on the same edge.
- SETTLE: one cycle with start=0. cur_floor is now the new floor. Decision rule:
  - If match: go to DOOR, load the counter and clear the bit.
  - Else if req_floor is nonzero: go to MOVE with trav_cnt reloaded.
  - Else go to IDLE.
- DOOR:
  - door_open=1 and door_cnt decrements.
  - A new edge on the cur_floor button reloads door_cnt to DOOR_CYCLES-1 (re-open). That bit is not latched.
  - At door_cnt==0, apply the SETTLE decision rule in the same cycle.
  - door_open drops the cycle after door_cnt==0.
- start is never high outside MOVE, and is never high in two consecutive cycles.
- Direction choice and priority when requests exist on both sides belong to the floor FSM. This block only exposes req_floor.
- If requests are cleared while in MOVE (reset excepted), the step still completes. SETTLE then returns to IDLE.

Test Plan:
1. Reset, cur_floor=001, btn_call=000 for 20 clocks -> pending=000, start never high, door_open=0, busy=0.
2. TRAVEL_CYCLES=4, DOOR_CYCLES=6, at floor 001: pulse btn_call[2] for 3 clocks ->
   - pending=100 at edge k+3; busy rises the next edge.
   - start pulses once after 4 MOVE clocks. The model FSM goes to 010, SETTLE, MOVE, second start, cur_floor=100.
   - SETTLE, then DOOR: door_open high 6 clocks, pending returns to 000, then IDLE.
3. At floor 010, press btn_call[1] -> DOOR entered directly from IDLE with no start pulse; pending[1] cleared on entry.
4. During DOOR at floor 010, re-press btn_call[1] at dwell clock 4 -> door_open extends to 4+6 clocks total; pending[1] stays 0.
5. At floor 001, press btn_call[2] then btn_call[1] mid-travel ->
   - lift stops at 010 and opens the door for 6 clocks;
   - then continues to 100 and opens the door; final pending=000.
6. Assert rst_n low during MOVE with trav_cnt=2 -> start never pulses; all outputs 0 immediately; IDLE after release.
